reg_write_queue: RTL and testbench

REG_WRITE_QUEUE -- requirements
Module: reg_write_queue

---
 rtl/reg_write_queue.sv | 110 +++++++++++
 tb/tb_reg_write_queue.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/reg_write_queue.sv
// reg_write_queue: 4-entry in-order FIFO of pending register-file writes.
// Drain: the head entry is offered to the register file whenever the queue is
// non-empty and drain_en is high, and it is popped on that same edge.
// Read forwarding: src_dataK can be taken from the youngest pending entry that
// targets src_regK. This is compiled in only when REG_WRITE_QUEUE_FWD_EN is defined.
// Latency: push in cycle N is visible at the head and drainable in cycle N+1.
// Backpressure: wr_ready is low only when the queue is full. A full queue refuses
// pushes even in a cycle that also pops.
// Ports:
//   clk, rst                             clock and synchronous active-high reset
//   wr_valid/wr_ready/wr_reg/wr_data     producer write request
//   drain_en, rf_write_reg, rf_dst_*     register-file write port
//   src_regK, rf_src_dataK, src_dataK    read IDs, raw read data, coherent read data
//   count                                occupancy, 0..4
module reg_write_queue #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_valid,
    input  logic [3:0]  wr_reg,
    input  logic [15:0] wr_data,
    output logic        wr_ready,
    input  logic        drain_en,
    output logic [3:0]  rf_dst_reg,
    output logic [15:0] rf_dst_data,
    output logic        rf_write_reg,
    input  logic [3:0]  src_reg1,
    input  logic [3:0]  src_reg2,
    input  logic [15:0] rf_src_data1,
    input  logic [15:0] rf_src_data2,
    output logic [15:0] src_data1,
    output logic [15:0] src_data2,
    output logic [2:0]  count
);

    localparam logic [2:0] LP_FULL = 3'(DEPTH);

    logic [3:0]  r_reg  [0:3];
    logic [15:0] r_data [0:3];
    logic [1:0]  r_head;
    logic [1:0]  r_tail;
    logic [2:0]  r_count;

    logic w_push;
    logic w_pop;
    logic w_empty;

    assign w_empty      = (r_count == 3'd0);
    assign wr_ready     = (r_count != LP_FULL);
    assign rf_write_reg = !w_empty && drain_en;
    assign w_push       = wr_valid && wr_ready;
    assign w_pop        = rf_write_reg;
    assign count        = r_count;

    assign rf_dst_reg  = w_empty ? 4'd0  : r_reg[r_head];
    assign rf_dst_data = w_empty ? 16'd0 : r_data[r_head];

    // Pointers and occupancy. 2-bit pointers wrap naturally from 3 to 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_head  <= 2'd0;
            r_tail  <= 2'd0;
            r_count <= 3'd0;
        end else begin
            if (w_push) r_tail <= r_tail + 2'd1;
            if (w_pop)  r_head <= r_head + 2'd1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 3'd1;
                2'b01:   r_count <= r_count - 3'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage is not reset. Occupancy alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            r_reg[r_tail]  <= wr_reg;
            r_data[r_tail] <= wr_data;
        end
    end

`ifdef REG_WRITE_QUEUE_FWD_EN
    // Scan from oldest (head) to youngest, so the last match wins.
    // The head entry still counts while it is being popped, because the register
    // file only captures it at the end of this cycle.
    // Same-cycle wr_* inputs are deliberately not searched.
    always_comb begin
        logic [1:0] w_idx;
        w_idx     = 2'd0;
        src_data1 = rf_src_data1;
        src_data2 = rf_src_data2;
        for (int i = 0; i < 4; i++) begin
            w_idx = r_head + i[1:0];
            if (3'(i) < r_count) begin
                if (r_reg[w_idx] == src_reg1) src_data1 = r_data[w_idx];
                if (r_reg[w_idx] == src_reg2) src_data2 = r_data[w_idx];
            end
        end
    end
`else
    // Without forwarding, read data passes straight through and the read IDs are unused here.
    logic w_unused_src;
    assign w_unused_src = ^{src_reg1, src_reg2};
    assign src_data1    = rf_src_data1;
    assign src_data2    = rf_src_data2;
`endif

endmodule

// File: tb/tb_reg_write_queue.sv
module tb_reg_write_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_valid;
    logic [3:0]  wr_reg;
    logic [15:0] wr_data;
    logic        wr_ready;
    logic        drain_en;
    logic [3:0]  rf_dst_reg;
    logic [15:0] rf_dst_data;
    logic        rf_write_reg;
    logic [3:0]  src_reg1, src_reg2;
    logic [15:0] rf_src_data1, rf_src_data2;
    logic [15:0] src_data1, src_data2;
    logic [2:0]  count;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    reg_write_queue #(.DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .wr_valid(wr_valid), .wr_reg(wr_reg), .wr_data(wr_data), .wr_ready(wr_ready),
        .drain_en(drain_en), .rf_dst_reg(rf_dst_reg), .rf_dst_data(rf_dst_data),
        .rf_write_reg(rf_write_reg),
        .src_reg1(src_reg1), .src_reg2(src_reg2),
        .rf_src_data1(rf_src_data1), .rf_src_data2(rf_src_data2),
        .src_data1(src_data1), .src_data2(src_data2),
        .count(count)
    );

    // Advance one rising edge, then settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [15:0] exp_fwd;

        rst = 1'b1; wr_valid = 1'b0; wr_reg = 4'd0; wr_data = 16'd0; drain_en = 1'b0;
        src_reg1 = 4'd3; src_reg2 = 4'd8; rf_src_data1 = 16'hAAAA; rf_src_data2 = 16'h5555;
        tick();
        tick();
        rst = 1'b0;
        drain_en = 1'b1;
        #1;
        check("reset_count",    count, 3'd0);
        check("reset_wr_ready", wr_ready, 1'b1);
        check("reset_rf_write", rf_write_reg, 1'b0);
        check("reset_src1",     src_data1, 16'hAAAA);

        // A single push drains on the next cycle.
        wr_valid = 1'b1; wr_reg = 4'd3; wr_data = 16'h1234;
        tick();
        wr_valid = 1'b0;
        #1;
        check("lat_rf_write", rf_write_reg, 1'b1);
        check("lat_dst_reg",  rf_dst_reg, 4'd3);
        check("lat_dst_data", rf_dst_data, 16'h1234);
        check("lat_count1",   count, 3'd1);
        tick();
        check("lat_count0",   count, 3'd0);
        check("lat_idle_wr",  rf_write_reg, 1'b0);
        check("lat_idle_dat", rf_dst_data, 16'h0000);

        // Five pushes with drain disabled: the fifth is refused.
        drain_en = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            wr_valid = 1'b1; wr_reg = 4'(k); wr_data = 16'h1000 + 16'(k);
            #1;
            check($sformatf("fill_ready_%0d", k), wr_ready, (k == 5) ? 1'b0 : 1'b1);
            tick();
        end
        wr_valid = 1'b0;
        #1;
        check("full_count", count, 3'd4);
        check("full_ready", wr_ready, 1'b0);
        drain_en = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            #1;
            check($sformatf("drain_wr_%0d", k),   rf_write_reg, 1'b1);
            check($sformatf("drain_reg_%0d", k),  rf_dst_reg, 4'(k));
            check($sformatf("drain_data_%0d", k), rf_dst_data, 16'h1000 + 16'(k));
            tick();
        end
        check("drained_count", count, 3'd0);
        check("drained_wr",    rf_write_reg, 1'b0);

        // Fill with two writes to R7, then R9 and R10.
        drain_en = 1'b0;
        wr_valid = 1'b1; wr_reg = 4'd7;  wr_data = 16'h0001; tick();
        wr_reg = 4'd7;  wr_data = 16'h0002; tick();
        wr_reg = 4'd9;  wr_data = 16'h0009; tick();
        wr_reg = 4'd10; wr_data = 16'h000A; tick();
        wr_valid = 1'b0;
        src_reg1 = 4'd7; rf_src_data1 = 16'hFFFF;
        src_reg2 = 4'd8; rf_src_data2 = 16'h5555;
        #1;
        check("fill2_count", count, 3'd4);
`ifdef REG_WRITE_QUEUE_FWD_EN
        exp_fwd = 16'h0002;
`else
        exp_fwd = 16'hFFFF;
`endif
        check("fwd_youngest_r7", src_data1, exp_fwd);
        check("fwd_nomatch_r8",  src_data2, 16'h5555);

        // Full queue: a push in the same cycle as a pop is still refused.
        drain_en = 1'b1;
        wr_valid = 1'b1; wr_reg = 4'd12; wr_data = 16'hCCCC;
        #1;
        check("fullpop_ready",   wr_ready, 1'b0);
        check("fullpop_wr",      rf_write_reg, 1'b1);
        check("fullpop_reg",     rf_dst_reg, 4'd7);
        check("fullpop_data",    rf_dst_data, 16'h0001);
        check("fwd_during_pop",  src_data1, exp_fwd);
        tick();
        wr_valid = 1'b0; drain_en = 1'b0;
        #1;
        check("fullpop_count",   count, 3'd3);
        check("fullpop_nxt_reg", rf_dst_reg, 4'd7);
        check("fullpop_nxt_dat", rf_dst_data, 16'h0002);

        // Reset with 3 entries pending; a push/pop in the reset cycle has no effect.
        rst = 1'b1; drain_en = 1'b1; wr_valid = 1'b1; wr_reg = 4'd5; wr_data = 16'h5A5A;
        tick();
        rst = 1'b0; wr_valid = 1'b0; rf_src_data1 = 16'h1111;
        #1;
        check("rst_mid_count", count, 3'd0);
        check("rst_mid_wr",    rf_write_reg, 1'b0);
        check("rst_mid_ready", wr_ready, 1'b1);
        check("rst_mid_src1",  src_data1, 16'h1111);
        tick();
        tick();
        check("rst_after_count", count, 3'd0);
        check("rst_after_wr",    rf_write_reg, 1'b0);

        // Same-cycle push is not a forwarding source; the next cycle it is.
        drain_en = 1'b0;
        src_reg1 = 4'd5;
        wr_valid = 1'b1; wr_reg = 4'd5; wr_data = 16'h7777;
        #1;
        check("fwd_excl_wr", src_data1, 16'h1111);
        tick();
        wr_valid = 1'b0;
        #1;
`ifdef REG_WRITE_QUEUE_FWD_EN
        exp_fwd = 16'h7777;
`else
        exp_fwd = 16'h1111;
`endif
        check("fwd_next_cycle", src_data1, exp_fwd);
        check("fwd_cnt1",       count, 3'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
